exp_job_sequencer: RTL and testbench

Upstream job sequencer for the series-evaluation engine (controller plus datapath). It buffers incoming operands in a small FIFO and presents each one on the engine's x bus. It issues the one-cycle `start` pulse, tracks the engine's `done` fall/rise, and captures the accumulator result into a valid/ready output register. A sticky error flag records engine hangs.

---
 rtl/exp_job_sequencer.sv | 154 +++++++++++++++
 tb/tb_exp_job_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exp_job_sequencer
// Purpose  : Buffers operands in a small FIFO, launches one series-evaluation
//            job at a time on the engine, and captures each result into a
//            valid/ready output register. Sticky err flags engine hangs.
// Revision : 1.0 - initial release
// ============================================================================
module exp_job_sequencer #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] x_out,
    output logic         start,
    input  logic         done,
    input  logic [W-1:0] r_in,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter must hold both the 4-cycle no-response window and TIMEOUT-1
    localparam int CW = (TIMEOUT > 8) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_OUT       = 3'd4
    } state_t;

    state_t          state;
    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            launch;

    // FIFO is full when occupancy reaches DEPTH; launch is the only pop
    assign in_ready = (count != (PW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign launch   = (state == S_IDLE) && (count != '0) && !out_valid && done;

    // Operand storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, launch})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Job control FSM with registered start/busy/err and the result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            x_out     <= '0;
            start     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        // x_out only ever changes here, so it is stable for the whole job
                        x_out <= mem[rd_ptr];
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!done) begin
                        cnt   <= '0;
                        state <= S_WAIT_DONE;
                    end else if (cnt == CW'(3)) begin
                        // Engine never acknowledged the start: drop the job
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        out_data  <= r_in;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Engine hung mid-job: give up without producing a result
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_job_sequencer
// Purpose  : Scoreboard bench for exp_job_sequencer with a behavioural engine
//            model (result = 6*x + 2, per-job latency or stuck-done).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_out;
    logic        start;
    logic        done;
    logic [15:0] r_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit stuck;
        int lat;
    } job_t;

    job_t        jobq[$];
    logic [15:0] xq[$];
    logic [15:0] resq[$];

    exp_job_sequencer #(.W(16), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .start     (start),
        .done      (done),
        .r_in      (r_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, required none, at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine model: on start, drop done the following cycle, raise it lat cycles later
    job_t        ej;
    int          eng_st  = 0;
    int          eng_cnt = 0;
    int          eng_lat = 0;
    logic [15:0] eng_x   = '0;
    always @(negedge clk) begin
        if (!rst) begin
            done   = 1'b1;
            eng_st = 0;
        end else begin
            case (eng_st)
                0: if (start) begin
                    if (jobq.size() > 0) ej = jobq.pop_front();
                    else begin ej.stuck = 1'b0; ej.lat = 5; end
                    eng_x   = x_out;
                    eng_lat = ej.lat;
                    if (!ej.stuck) eng_st = 1;
                end
                1: begin
                    done    = 1'b0;
                    eng_cnt = eng_lat;
                    eng_st  = 2;
                end
                2: begin
                    eng_cnt--;
                    if (eng_cnt <= 0) begin
                        done   = 1'b1;
                        r_in   = eng_x * 16'd6 + 16'd2;
                        eng_st = 0;
                    end
                end
                default: eng_st = 0;
            endcase
        end
    end

    // Monitor: operand at each start, operand stability, result at each handshake
    logic [15:0] cur_x = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (start) begin
                if (xq.size() == 0) unexpected("start_unexpected");
                else check("x_at_start", x_out, xq.pop_front());
                cur_x = x_out;
            end else if (busy) begin
                check("x_held", x_out, cur_x);
            end
            if (out_valid && out_ready) begin
                if (resq.size() == 0) unexpected("result_unexpected");
                else check("result", out_data, resq.pop_front());
            end
        end
    end

    task automatic push(input logic [15:0] x, input int lat, input bit stuck,
                        input bit has_res, input logic [15:0] res);
        bit   accepted = 1'b0;
        job_t jb;
        in_data  = x;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !accepted; t++) begin
            if (in_ready) begin
                accepted = 1'b1;
                jb.stuck = stuck;
                jb.lat   = lat;
                jobq.push_back(jb);
                xq.push_back(x);
                if (has_res) resq.push_back(res);
            end
            tick();
        end
        in_valid = 1'b0;
        if (!accepted) unexpected("push_timeout");
    endtask

    task automatic wait_start(input string name);
        int t = 0;
        while (!start && t < 300) begin tick(); t++; end
        if (!start) unexpected(name);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((xq.size() != 0 || resq.size() != 0 || busy) && t < 600) begin tick(); t++; end
        if (xq.size() != 0 || resq.size() != 0 || busy) unexpected(name);
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ov;
        int t;
        rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        done = 1'b1; r_in = '0;
        tick(); tick();
        check("rst_start", start, 0);
        check("rst_x_out", x_out, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // Single job: push at cycle 0, start exactly at cycle 2
        push(16'h0003, 10, 1'b0, 1'b1, 16'h0014);
        check("single_c1_start", start, 0);
        check("single_c1_busy", busy, 0);
        tick();
        check("single_c2_start", start, 1);
        check("single_c2_x", x_out, 16'h0003);
        check("single_c2_busy", busy, 1);
        tick();
        check("single_c3_start", start, 0);
        drain("single_drain");
        check("single_err", err, 0);

        // FIFO full: four queued behind a busy engine, fifth held off
        push(16'h0010, 30, 1'b0, 1'b1, 16'h0062);
        wait_start("full_blocker_start");
        check("full_ready0", in_ready, 1);
        push(16'h0001, 5, 1'b0, 1'b1, 16'h0008);
        check("full_ready1", in_ready, 1);
        push(16'h0002, 5, 1'b0, 1'b1, 16'h000E);
        check("full_ready2", in_ready, 1);
        push(16'h0004, 5, 1'b0, 1'b1, 16'h001A);
        check("full_ready3", in_ready, 1);
        push(16'h0005, 5, 1'b0, 1'b1, 16'h0020);
        check("full_ready_low", in_ready, 0);
        push(16'h0007, 5, 1'b0, 1'b1, 16'h002C);
        drain("full_drain");

        // Backpressure: hold result for 20 cycles, no new start meanwhile
        out_ready = 1'b0;
        push(16'h0100, 5, 1'b0, 1'b1, 16'h0602);
        push(16'h0009, 5, 1'b0, 1'b1, 16'h0038);
        t = 0;
        while (!out_valid && t < 200) begin tick(); t++; end
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 16'h0602);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 16'h0602);
            check("bp_no_start", start, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", out_valid, 0);
        drain("bp_drain");

        // No-response: done stuck high, err after 4 cycles in WAIT_BUSY
        push(16'h00AA, 0, 1'b1, 1'b0, 16'h0000);
        wait_start("stuck_start");
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) begin
                check("stuck_err_k4", err, 0);
                check("stuck_busy_k4", busy, 1);
            end
            if (k == 5) begin
                check("stuck_err_k5", err, 1);
                check("stuck_busy_k5", busy, 0);
            end
        end
        rst = 1'b0;
        #1;
        check("rst_clears_err", err, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Hang: done low past TIMEOUT, err, then the queued job still runs
        push(16'h00BB, 100, 1'b0, 1'b0, 16'h0000);
        push(16'h000A, 5, 1'b0, 1'b1, 16'h003E);
        wait_start("hang_start");
        seen_ov = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            tick();
            seen_ov = seen_ov | out_valid;
            if (k == 65) check("hang_err_k65", err, 0);
            if (k == 66) check("hang_err_k66", err, 1);
        end
        check("hang_no_out", seen_ov, 0);
        wait_start("hang_next_start");
        drain("hang_drain");
        check("hang_err_sticky", err, 1);

        // Asynchronous reset mid-job with two items queued
        push(16'h0011, 30, 1'b0, 1'b0, 16'h0000);
        wait_start("rstmid_start");
        push(16'h0012, 5, 1'b0, 1'b0, 16'h0000);
        push(16'h0013, 5, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_start", start, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_err", err, 0);
        xq.delete();
        resq.delete();
        jobq.delete();
        tick(); tick();
        rst = 1'b1;
        repeat (60) tick();
        check("rstmid_after_valid", out_valid, 0);
        check("rstmid_after_busy", busy, 0);

        check("xq_empty", xq.size(), 0);
        check("resq_empty", resq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
